// File: rtl/rcn_uart_rx_deframer_pkg.sv
// rtl/rcn_uart_rx_deframer_pkg.sv - shared state encoding and helpers for the UART receive deframer
package rcn_uart_rx_deframer_pkg;

  localparam int RCN_UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rcn_uart_sample_tick.sv
// rtl/rcn_uart_sample_tick.sv - free-running oversample tick divider, shared with the transmit side
// tick_o is high for one cycle every DIV+1 clocks; the count is never restarted by a data path.
module rcn_uart_sample_tick #(
  parameter logic [5:0] DIV = 6'd61
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [5:0] cnt_q;

  assign tick_o = (cnt_q == DIV);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 6'd0;
    end else if (tick_o) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/rcn_uart_rx_deframer.sv
// rtl/rcn_uart_rx_deframer.sv - oversampling UART receive deframer with glitch, frame-error and break detection
// Optional even-parity checking is compiled in with RCN_UART_RX_PARITY_EN.
module rcn_uart_rx_deframer
  import rcn_uart_rx_deframer_pkg::*;
#(
  parameter logic [5:0] SAMPLE_CLK_DIV  = 6'd61,
  parameter logic [2:0] SAMPLES_PER_BIT = 3'd7
) (
  input  logic                          clk_50,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          rx_vld,
  output logic [RCN_UART_DATA_BITS-1:0] rx_data,
  output logic                          rx_frame_error,
  output logic                          rx_break,
  output logic                          rx_busy
);

  localparam logic [2:0] S_MID    = SAMPLES_PER_BIT >> 1;
  localparam logic [2:0] S_DECIDE = S_MID + 3'd1;
  localparam logic [2:0] S_LAST   = SAMPLES_PER_BIT - 3'd1;
  localparam logic [2:0] BIT_LAST = 3'(RCN_UART_DATA_BITS - 1);

  logic                          sync_q, rxs_q;
  logic                          tick;
  rx_state_e                     state_q;
  logic [2:0]                    s_q, bit_q;
  logic [1:0]                    samp_q;
  logic [RCN_UART_DATA_BITS-1:0] shift_q, data_q;
  logic                          vld_q, fe_q, brk_q;
  logic                          maj_d, decide_d, bit_end_d;
`ifdef RCN_UART_RX_PARITY_EN
  logic                          par_q;
`endif

  rcn_uart_sample_tick #(.DIV(SAMPLE_CLK_DIV)) u_tick (
    .clk_i (clk_50),
    .rst_i (rst),
    .tick_o(tick)
  );

  // samp_q holds the samples from s=M-1 and s=M; the current rxs_q is the s=M+1 sample.
  assign maj_d     = maj3(samp_q[1], samp_q[0], rxs_q);
  assign decide_d  = tick && (s_q == S_DECIDE);
  assign bit_end_d = tick && (s_q == S_LAST);

  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= ST_IDLE;
      s_q     <= 3'd0;
      bit_q   <= 3'd0;
      samp_q  <= 2'b11;
      shift_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
`ifdef RCN_UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q <= uart_rx;
      rxs_q  <= sync_q;
      vld_q  <= 1'b0;
      fe_q   <= 1'b0;
      if (tick) begin
        samp_q <= {samp_q[0], rxs_q};
      end
      if (tick && state_q != ST_IDLE) begin
        s_q <= (s_q == S_LAST) ? 3'd0 : s_q + 3'd1;
      end
      case (state_q)
        ST_IDLE: begin
          s_q <= 3'd0;
          if (tick && !rxs_q) begin
            state_q <= ST_START;
            s_q     <= 3'd1;
          end
        end
        ST_START: begin
          if (decide_d && maj_d) begin
            state_q <= ST_IDLE;
          end else if (bit_end_d) begin
            state_q <= ST_DATA;
            bit_q   <= 3'd0;
          end
        end
        ST_DATA: begin
          if (decide_d) begin
            shift_q <= {maj_d, shift_q[RCN_UART_DATA_BITS-1:1]};
          end
          if (bit_end_d) begin
            if (bit_q == BIT_LAST) begin
`ifdef RCN_UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
`ifdef RCN_UART_RX_PARITY_EN
        ST_PARITY: begin
          if (decide_d) begin
            par_q <= maj_d;
          end
          if (bit_end_d) begin
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave mid-stop-bit on a good stop so a back-to-back start edge is caught.
          if (decide_d) begin
            if (maj_d) begin
              state_q <= ST_IDLE;
`ifdef RCN_UART_RX_PARITY_EN
              if ((^shift_q) ^ par_q) begin
                fe_q <= 1'b1;
              end else begin
                data_q <= shift_q;
                vld_q  <= 1'b1;
              end
`else
              data_q <= shift_q;
              vld_q  <= 1'b1;
`endif
            end else begin
              fe_q    <= 1'b1;
              brk_q   <= (shift_q == '0);
              state_q <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (tick && rxs_q) begin
            brk_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_vld         = vld_q;
  assign rx_data        = data_q;
  assign rx_frame_error = fe_q;
  assign rx_break       = brk_q;
  assign rx_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rcn_uart_rx_deframer.sv
// tb/tb_rcn_uart_rx_deframer.sv - directed self-checking bench for rcn_uart_rx_deframer
// Runs with SAMPLE_CLK_DIV=3, SAMPLES_PER_BIT=7, so one bit is 28 clocks.
module tb_rcn_uart_rx_deframer;

  localparam int BIT_CYC = 28;

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       rx_frame_error;
  logic       rx_break;
  logic       rx_busy;

  int tests = 0;
  int fails = 0;
  int vld_cnt = 0;
  int fe_cnt = 0;
  int vb, fb;
  logic [7:0] log_q [0:63];

  rcn_uart_rx_deframer #(
    .SAMPLE_CLK_DIV (6'd3),
    .SAMPLES_PER_BIT(3'd7)
  ) dut (
    .clk_50        (clk_50),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .rx_vld        (rx_vld),
    .rx_data       (rx_data),
    .rx_frame_error(rx_frame_error),
    .rx_break      (rx_break),
    .rx_busy       (rx_busy)
  );

  always #5 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (!rst) begin
      if (rx_vld) begin
        log_q[vld_cnt[5:0]] = rx_data;
        vld_cnt = vld_cnt + 1;
      end
      if (rx_frame_error) begin
        fe_cnt = fe_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk_50);
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (BIT_CYC) @(negedge clk_50);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RCN_UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
    uart_rx = 1'b1;
  endtask

`ifdef RCN_UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
    uart_rx = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk_50);
    chk("reset_vld", 32'(rx_vld), 32'd0);
    chk("reset_data", 32'(rx_data), 32'h00);
    chk("reset_fe", 32'(rx_frame_error), 32'd0);
    chk("reset_break", 32'(rx_break), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(2 * BIT_CYC);

    vb = vld_cnt; fb = fe_cnt;
    send_frame(8'hA5, 1'b1);
    chk("a5_busy_after_stop", 32'(rx_busy), 32'd0);
    chk("a5_vld_count", 32'(vld_cnt - vb), 32'd1);
    chk("a5_data_log", 32'(log_q[vb[5:0]]), 32'hA5);
    chk("a5_data_held", 32'(rx_data), 32'hA5);
    chk("a5_fe_count", 32'(fe_cnt - fb), 32'd0);
    idle(BIT_CYC);

    vb = vld_cnt; fb = fe_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(BIT_CYC);
    chk("b2b_vld_count", 32'(vld_cnt - vb), 32'd2);
    chk("b2b_first", 32'(log_q[vb[5:0]]), 32'h3C);
    chk("b2b_second", 32'(log_q[6'(vb + 1)]), 32'hC3);
    chk("b2b_fe_count", 32'(fe_cnt - fb), 32'd0);

    vb = vld_cnt; fb = fe_cnt;
    uart_rx = 1'b0;
    repeat (8) @(negedge clk_50);
    uart_rx = 1'b1;
    repeat (BIT_CYC) @(negedge clk_50);
    chk("glitch_busy", 32'(rx_busy), 32'd0);
    chk("glitch_vld_count", 32'(vld_cnt - vb), 32'd0);
    chk("glitch_fe_count", 32'(fe_cnt - fb), 32'd0);

    vb = vld_cnt; fb = fe_cnt;
    send_frame(8'h55, 1'b0);
    chk("badstop_wait_busy", 32'(rx_busy), 32'd1);
    chk("badstop_break_low", 32'(rx_break), 32'd0);
    idle(2 * BIT_CYC);
    chk("badstop_fe_count", 32'(fe_cnt - fb), 32'd1);
    chk("badstop_vld_count", 32'(vld_cnt - vb), 32'd0);
    chk("badstop_data_kept", 32'(rx_data), 32'hC3);
    chk("badstop_break", 32'(rx_break), 32'd0);
    chk("badstop_busy", 32'(rx_busy), 32'd0);

    vb = vld_cnt; fb = fe_cnt;
    uart_rx = 1'b0;
    repeat (15 * BIT_CYC) @(negedge clk_50);
    chk("break_mid_level", 32'(rx_break), 32'd1);
    chk("break_mid_fe_count", 32'(fe_cnt - fb), 32'd1);
    repeat (15 * BIT_CYC) @(negedge clk_50);
    chk("break_end_level", 32'(rx_break), 32'd1);
    chk("break_end_fe_count", 32'(fe_cnt - fb), 32'd1);
    chk("break_vld_count", 32'(vld_cnt - vb), 32'd0);
    uart_rx = 1'b1;
    @(negedge clk_50);
    chk("break_held_after_release", 32'(rx_break), 32'd1);
    repeat (10) @(negedge clk_50);
    chk("break_cleared", 32'(rx_break), 32'd0);
    chk("break_busy_cleared", 32'(rx_busy), 32'd0);
    idle(BIT_CYC);
    vb = vld_cnt; fb = fe_cnt;
    send_frame(8'h81, 1'b1);
    idle(BIT_CYC);
    chk("after_break_vld_count", 32'(vld_cnt - vb), 32'd1);
    chk("after_break_data", 32'(rx_data), 32'h81);
    chk("after_break_fe_count", 32'(fe_cnt - fb), 32'd0);

`ifdef RCN_UART_RX_PARITY_EN
    vb = vld_cnt; fb = fe_cnt;
    send_frame_par(8'h07, 1'b1);
    idle(BIT_CYC);
    chk("par_good_vld_count", 32'(vld_cnt - vb), 32'd1);
    chk("par_good_data", 32'(rx_data), 32'h07);
    chk("par_good_fe_count", 32'(fe_cnt - fb), 32'd0);
    vb = vld_cnt; fb = fe_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(BIT_CYC);
    chk("par_bad_vld_count", 32'(vld_cnt - vb), 32'd0);
    chk("par_bad_fe_count", 32'(fe_cnt - fb), 32'd1);
    chk("par_bad_busy", 32'(rx_busy), 32'd0);
`endif

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("rst_mid_data_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk_50);
    chk("rst_mid_vld", 32'(rx_vld), 32'd0);
    chk("rst_mid_data", 32'(rx_data), 32'h00);
    chk("rst_mid_fe", 32'(rx_frame_error), 32'd0);
    chk("rst_mid_break", 32'(rx_break), 32'd0);
    chk("rst_mid_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    idle(2 * BIT_CYC);
    vb = vld_cnt; fb = fe_cnt;
    send_frame(8'hFF, 1'b1);
    idle(BIT_CYC);
    chk("post_rst_vld_count", 32'(vld_cnt - vb), 32'd1);
    chk("post_rst_data", 32'(rx_data), 32'hFF);
    chk("post_rst_fe_count", 32'(fe_cnt - fb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
